// File: rtl/periph_share_arb.sv
// periph_share_arb: round-robin arbiter serializing N_MASTERS requesters onto one single-transaction slave.
// Define PSARB_TIMEOUT_EN to force completion (all-ones data, sticky timeout_err) after TIMEOUT_CYC WAIT cycles.
module periph_share_arb #(
  parameter int unsigned N_MASTERS   = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic                            busy,
  output logic                            timeout_err,
  input  logic                            err_clr
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, grant, sel_c, ptr_nxt_c;
  logic [N_MASTERS-1:0] rot_c;
  logic               req_c, load_c, done_c, tmo_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [DATA_W-1:0]  sel_wdata_c;
  logic [STRB_W-1:0]  sel_wstrb_c;

  // Round-robin pick: rotate requests so ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    req_c     = 1'b0;
    sel_c     = ptr;
    rot_c     = N_MASTERS'({m_valid, m_valid} >> ptr);
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (!req_c && rot_c[i]) begin
        req_c = 1'b1;
        sel_c = IDX_W'((32'(ptr) + i) % N_MASTERS);
      end
    end
    ptr_nxt_c = IDX_W'((32'(sel_c) + 1) % N_MASTERS);
  end

  // Payload of the selected master.
  always_comb begin
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_wstrb_c = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (IDX_W'(i) == sel_c) begin
        sel_addr_c  = m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_c = m_wdata[i*DATA_W +: DATA_W];
        sel_wstrb_c = m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // Next-state logic; s_ready outside ISSUE/WAIT is ignored.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (req_c) begin
          load_c    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (s_ready) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (s_ready || tmo_c) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
    end else begin
      state <= state_nxt;
      if (load_c) begin
        grant   <= sel_c;
        ptr     <= ptr_nxt_c;
        s_addr  <= sel_addr_c;
        s_wdata <= sel_wdata_c;
        s_wstrb <= sel_wstrb_c;
      end
    end
  end

  assign s_valid = (state == ISSUE);
  assign busy    = (state != IDLE);

  // Completion is routed straight through so a combinational slave finishes in ISSUE.
  always_comb begin
    m_ready = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (done_c && (IDX_W'(i) == grant)) m_ready[i] = 1'b1;
    end
    m_rdata = tmo_c ? '1 : s_rdata;
  end

`ifdef PSARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_c = (state == WAIT) && !s_ready && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Counter is zero on WAIT entry; a new timeout beats a simultaneous err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);
      else               tmo_cnt <= '0;
      if (tmo_c)        timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end
`else
  logic unused_c;
  assign tmo_c       = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_c    = ^{err_clr, 32'(TIMEOUT_CYC)};
`endif

endmodule

// File: tb/tb_periph_share_arb.sv
// Self-checking bench for periph_share_arb: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_periph_share_arb;
  localparam int unsigned N  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic            busy, timeout_err, err_clr;

  int n_cmp, n_err;

  logic [AW-1:0] pa [N];
  logic [DW-1:0] pd [N];
  logic [SW-1:0] ps [N];

  always #5 clk = ~clk;

  periph_share_arb #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready), .s_valid(s_valid),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  // Slave model: register file, latency lat cycles after s_valid (comb_mode = same cycle).
  logic [DW-1:0] regs [16];
  logic comb_mode, hold_mode, man_rdy, rdy_q;
  int   lat, pend;
  assign s_rdata = regs[s_addr];
  assign s_ready = man_rdy | (comb_mode ? s_valid : rdy_q);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
      pend  <= 0;
    end else begin
      rdy_q <= 1'b0;
      if (!comb_mode && !hold_mode) begin
        if (s_valid) begin
          if (lat <= 1) rdy_q <= 1'b1;
          else          pend  <= lat - 1;
        end else if (pend > 0) begin
          if (pend == 1) rdy_q <= 1'b1;
          pend <= pend - 1;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_addr[i*AW +: AW]  = a;
    m_wdata[i*DW +: DW] = d;
    m_wstrb[i*SW +: SW] = s;
    pa[i] = a; pd[i] = d; ps[i] = s;
    m_valid[i] = 1'b1;
  endtask

  // Leaves the caller at the negedge where rst was released (cycle 0, DUT in IDLE).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m_valid = '0; man_rdy = 1'b0; err_clr = 1'b0;
    hold_mode = 1'b0; comb_mode = 1'b0; lat = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    man_rdy = 1'b1; m_valid = '1; #1;
    n_cmp++; if (s_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_ctrl: s_valid=%b busy=%b exp 0 0", s_valid, busy); end
    n_cmp++; if (s_addr !== '0 || s_wdata !== '0 || s_wstrb !== '0) begin n_err++; $display("FAIL reset_payload: %h %h %h exp zeros", s_addr, s_wdata, s_wstrb); end
    n_cmp++; if (m_ready !== '0) begin n_err++; $display("FAIL reset_mready: got %b exp 00", m_ready); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_terr: got %b exp 0", timeout_err); end
    man_rdy = 1'b0; m_valid = '0;
  endtask

  task automatic test_single_read();
    do_reset();
    regs[3] = 32'h0000_00A5;
    set_req(0, 4'h3, $urandom, 4'hF);
    @(negedge clk);
    n_cmp++; if (s_valid !== 1'b1 || s_addr !== 4'h3 || s_wdata !== pd[0]) begin n_err++; $display("FAIL single_issue: s_valid=%b s_addr=%h exp 1 3", s_valid, s_addr); end
    n_cmp++; if (m_ready !== 2'b00) begin n_err++; $display("FAIL single_early: m_ready=%b exp 00", m_ready); end
    @(negedge clk);
    n_cmp++; if (m_ready !== 2'b01 || m_rdata !== 32'h0000_00A5) begin n_err++; $display("FAIL single_done: m_ready=%b m_rdata=%h exp 01 000000a5", m_ready, m_rdata); end
    m_valid[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || m_ready !== 2'b00) begin n_err++; $display("FAIL single_idle: busy=%b m_ready=%b exp 0 00", busy, m_ready); end
  endtask

  task automatic test_contention();
    int ev;
    logic [N-1:0] e;
    do_reset();
    set_req(0, 4'h1, $urandom, 4'h3);
    set_req(1, 4'h2, $urandom, 4'hC);
    ev = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (m_ready !== '0) begin
        e = (ev % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++;
        if (ev >= 4 || m_ready !== e || c != 2 + 3 * ev) begin
          n_err++; $display("FAIL contention_grant%0d: m_ready=%b at cycle %0d exp %b at %0d", ev, m_ready, c, e, 2 + 3 * ev);
        end
        ev++;
      end
    end
    n_cmp++; if (ev != 4) begin n_err++; $display("FAIL contention_count: got %0d grants exp 4", ev); end
    m_valid = '0;
  endtask

  task automatic test_starvation();
    int ev0, got;
    do_reset();
    set_req(0, 4'h1, $urandom, 4'hF);
    ev0 = 0; got = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (m_ready !== '0) begin
        if (ev0 < 2) begin
          n_cmp++; if (m_ready !== 2'b01) begin n_err++; $display("FAIL starve_m0_%0d: m_ready=%b exp 01", ev0, m_ready); end
          ev0++;
          if (ev0 == 2) set_req(1, 4'h2, $urandom, 4'hF);
        end else if (got == 0) begin
          n_cmp++; if (m_ready !== 2'b10) begin n_err++; $display("FAIL starve_m1: m_ready=%b exp 10", m_ready); end
          got = 1; m_valid[1] = 1'b0;
        end else if (got == 1) begin
          n_cmp++; if (m_ready !== 2'b01) begin n_err++; $display("FAIL starve_m0_after: m_ready=%b exp 01", m_ready); end
          got = 2;
        end
      end
    end
    n_cmp++; if (got != 2) begin n_err++; $display("FAIL starve_count: stage %0d exp 2", got); end
    m_valid = '0;
  endtask

  task automatic test_comb_slave();
    logic [N-1:0] e;
    do_reset();
    comb_mode = 1'b1;
    set_req(0, 4'h7, $urandom, 4'h1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      e = (c % 2 == 1) ? 2'b01 : 2'b00;
      n_cmp++;
      if (m_ready !== e || busy !== e[0] || (e[0] && m_rdata !== regs[7])) begin
        n_err++; $display("FAIL comb_cycle%0d: m_ready=%b busy=%b rdata=%h exp %b %b %h", c, m_ready, busy, m_rdata, e, e[0], regs[7]);
      end
    end
    m_valid = '0;
    comb_mode = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    hold_mode = 1'b1;
    set_req(0, 4'h5, $urandom, 4'hF);
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || s_valid !== 1'b0) begin n_err++; $display("FAIL rstwait_inwait: busy=%b s_valid=%b exp 1 0", busy, s_valid); end
    rst = 1'b1; #1;
    n_cmp++; if ({s_valid, busy, m_ready, s_addr, s_wdata, s_wstrb} !== '0) begin n_err++; $display("FAIL rstwait_outputs: s_valid=%b busy=%b m_ready=%b s_addr=%h exp zeros", s_valid, busy, m_ready, s_addr); end
    @(negedge clk);
    rst = 1'b0; m_valid = '0; hold_mode = 1'b0;
    @(negedge clk);
    man_rdy = 1'b1; #1;
    n_cmp++; if (m_ready !== 2'b00) begin n_err++; $display("FAIL rstwait_late_ready: m_ready=%b exp 00", m_ready); end
    @(negedge clk);
    man_rdy = 1'b0;
    n_cmp++; if (busy !== 1'b0 || s_valid !== 1'b0) begin n_err++; $display("FAIL rstwait_idle: busy=%b s_valid=%b exp 0 0", busy, s_valid); end
    set_req(0, 4'h6, $urandom, 4'h2);
    set_req(1, 4'h9, $urandom, 4'h4);
    @(negedge clk);
    n_cmp++; if (s_valid !== 1'b1 || s_addr !== 4'h6) begin n_err++; $display("FAIL rstwait_ptr: s_valid=%b s_addr=%h exp 1 6", s_valid, s_addr); end
    @(negedge clk);
    n_cmp++; if (m_ready !== 2'b01) begin n_err++; $display("FAIL rstwait_grant: m_ready=%b exp 01", m_ready); end
    m_valid = '0;
    @(negedge clk);
  endtask

`ifdef PSARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [N-1:0] e;
    do_reset();
    hold_mode = 1'b1;
    set_req(0, 4'hA, $urandom, 4'hF);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      e = (c == 17) ? 2'b01 : 2'b00;
      n_cmp++;
      if (m_ready !== e || timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_cycle%0d: m_ready=%b terr=%b exp %b 0", c, m_ready, timeout_err, e); end
    end
    n_cmp++; if (m_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL timeout_rdata: got %h exp ffffffff", m_rdata); end
    m_valid = '0;
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL timeout_flag: terr=%b busy=%b exp 1 0", timeout_err, busy); end
    repeat (3) @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b exp 1", timeout_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_clr: got %b exp 0", timeout_err); end
    hold_mode = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    do_reset();
    hold_mode = 1'b1;
    set_req(0, 4'hA, $urandom, 4'hF);
    bad = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      err_clr = (c == 20);
      if (m_ready !== '0 || timeout_err !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL notimeout_wait: %0d bad cycles exp 0", bad); end
    err_clr = 1'b0;
    man_rdy = 1'b1; #1;
    n_cmp++; if (m_ready !== 2'b01 || m_rdata !== regs[10]) begin n_err++; $display("FAIL notimeout_done: m_ready=%b rdata=%h exp 01 %h", m_ready, m_rdata, regs[10]); end
    m_valid = '0;
    @(negedge clk);
    man_rdy = 1'b0; hold_mode = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL notimeout_idle: busy=%b exp 0", busy); end
  endtask
`endif

  // Transaction-level model: grant = first requester at/after rr in the sampled IDLE cycle.
  task automatic test_random();
    bit outstanding, idle_prev, reconf, exp_sv;
    logic [N-1:0] vprev, exp_mr;
    int rr, w, issue_cyc, cur_lat;
    int wait_cnt [N];
    do_reset();
    outstanding = 0; idle_prev = 1; reconf = 0; vprev = '0; rr = 0; w = 0; issue_cyc = 0; cur_lat = 1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      exp_sv = idle_prev && (vprev != '0);
      n_cmp++; if (s_valid !== exp_sv) begin n_err++; $display("FAIL rand_svalid@%0d: got %b exp %b", cyc, s_valid, exp_sv); end
      if (exp_sv) begin
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && vprev[(rr + k) % N]) w = (rr + k) % N;
        n_cmp++;
        if (s_addr !== pa[w] || s_wdata !== pd[w] || s_wstrb !== ps[w]) begin
          n_err++; $display("FAIL rand_payload@%0d: addr=%h wstrb=%h exp %h %h (master %0d)", cyc, s_addr, s_wstrb, pa[w], ps[w], w);
        end
        n_cmp++; if (wait_cnt[w] > N - 1) begin n_err++; $display("FAIL rand_fair@%0d: master %0d waited %0d exp <=%0d", cyc, w, wait_cnt[w], N - 1); end
        for (int i = 0; i < N; i++) if (i != w && vprev[i]) wait_cnt[i]++;
        wait_cnt[w] = 0;
        outstanding = 1; issue_cyc = cyc; cur_lat = lat; rr = (w + 1) % N;
      end
      n_cmp++; if (busy !== outstanding) begin n_err++; $display("FAIL rand_busy@%0d: got %b exp %b", cyc, busy, outstanding); end
      exp_mr = '0;
      if (outstanding && cyc == issue_cyc + cur_lat) exp_mr[w] = 1'b1;
      n_cmp++; if (m_ready !== exp_mr) begin n_err++; $display("FAIL rand_mready@%0d: got %b exp %b", cyc, m_ready, exp_mr); end
      if (exp_mr != '0) begin
        n_cmp++; if (m_rdata !== regs[pa[w]]) begin n_err++; $display("FAIL rand_rdata@%0d: got %h exp %h", cyc, m_rdata, regs[pa[w]]); end
      end
      idle_prev = !outstanding;
      if (reconf) begin
        lat = $urandom_range(0, 3);
        comb_mode = (lat == 0);
        reconf = 0;
      end
      if (exp_mr != '0) begin
        outstanding = 0; m_valid[w] = 1'b0; reconf = 1;
      end
      for (int i = 0; i < N; i++) begin
        if (!m_valid[i] && $urandom_range(0, 99) < 40) begin
          set_req(i, AW'($urandom), $urandom, SW'($urandom));
          wait_cnt[i] = 0;
        end
      end
      vprev = m_valid;
    end
    m_valid = '0;
    comb_mode = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    man_rdy = 1'b0; err_clr = 1'b0; comb_mode = 1'b0; hold_mode = 1'b0; lat = 1;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    test_reset();
    test_single_read();
    test_contention();
    test_starvation();
    test_comb_slave();
    test_reset_mid_wait();
`ifdef PSARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
